// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models mult/div latency
// with a down-counter. Results commit only when the counter expires.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_rdata
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          dz_q, dz_d;
    logic          eff;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, b_u, q_u, r_u;

    // Signed divide done on magnitudes so the most-negative / -1 case wraps
    // to 0x80000000 without relying on simulator overflow behaviour.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? -A : A;
        b_mag  = B[31] ? -B : B;
        if (b_mag == 32'd0) b_mag = 32'd1;
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        q_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
        r_s    = A[31] ? -r_mag : r_mag;
        b_u    = (B == 32'd0) ? 32'd1 : B;
        q_u    = A / b_u;
        r_u    = A % b_u;
    end

    assign eff = start & ~req & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (eff) begin
                    case (mdu_op)
                        4'd1: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d = CW'(MULT_CYCLES); dz_d = 1'b0; state_d = RUN;
                        end
                        4'd2: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d = CW'(MULT_CYCLES); dz_d = 1'b0; state_d = RUN;
                        end
                        4'd3: begin
                            pend_hi_d = r_s; pend_lo_d = q_s;
                            cnt_d = CW'(DIV_CYCLES); dz_d = (B == 32'd0); state_d = RUN;
                        end
                        4'd4: begin
                            pend_hi_d = r_u; pend_lo_d = q_u;
                            cnt_d = CW'(DIV_CYCLES); dz_d = (B == 32'd0); state_d = RUN;
                        end
                        4'd7:    hi_d = A;
                        4'd8:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign stall    = d_is_md & (busy | (start & ~req));
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_rdata = (mdu_op == 4'd5) ? hi_q : (mdu_op == 4'd6) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: latency, results, mthi/mtlo, req suppression,
// stall generation and async reset mid-operation.
module tb_e_mdu;
    logic        clk, reset, req, start, d_is_md;
    logic [3:0]  mdu_op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] HI, LO, md_rdata;

    int total = 0;
    int bad   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .mdu_op(mdu_op),
        .A(A), .B(B), .d_is_md(d_is_md), .busy(busy), .stall(stall),
        .HI(HI), .LO(LO), .md_rdata(md_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The hazard unit must never present a start while the unit is running.
    always @(negedge clk) if (start) chk("no_start_in_run", 64'(busy), 64'd0);

    // Called between a negedge and the next posedge; returns at a negedge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic r, input logic dmd, input int req_at,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] oh, ol;
        int cnt;
        oh = HI; ol = LO;
        mdu_op = op; A = a; B = b; start = 1'b1; req = r; d_is_md = dmd;
        #1 chk("stall_start", 64'(stall), 64'(dmd & ~r));
        @(posedge clk);
        #1 start = 1'b0; req = 1'b0; mdu_op = 4'd0; A = 32'hDEADBEEF; B = 32'h0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            chk("stall_busy", 64'(stall), 64'(dmd));
            chk("hilo_hold", {HI, LO}, {oh, ol});
            req = (cnt == req_at);
        end
        req = 1'b0;
        chk("busy_cycles", 64'(cnt), 64'(n));
        chk("stall_after", 64'(stall), 64'd0);
        chk("hi", 64'(HI), 64'(exp_hi));
        chk("lo", 64'(LO), 64'(exp_lo));
        d_is_md = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; req = 1'b0; d_is_md = 1'b0;
        mdu_op = 4'd0; A = '0; B = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // mult / multu
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op(4'd2, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 1'b1, 0, 32'h00000002, 32'hFFFFFFFA);
        // div / divu / divide-by-zero / overflow
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(4'd4, 32'd7, 32'd2, 10, 1'b0, 1'b1, 0, 32'd1, 32'd3);
        run_op(4'd3, 32'd5, 32'd0, 10, 1'b0, 1'b1, 0, 32'd1, 32'd3);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0, 0, 32'd0, 32'h80000000);
        // mthi / mtlo, then reads
        run_op(4'd7, 32'h12345678, 32'd0, 0, 1'b0, 1'b1, 0, 32'h12345678, 32'h80000000);
        run_op(4'd8, 32'h9ABCDEF0, 32'd0, 0, 1'b0, 1'b1, 0, 32'h12345678, 32'h9ABCDEF0);
        mdu_op = 4'd5; #1 chk("mfhi", 64'(md_rdata), 64'h12345678);
        mdu_op = 4'd6; #1 chk("mflo", 64'(md_rdata), 64'h9ABCDEF0);
        mdu_op = 4'd0; #1 chk("md_none", 64'(md_rdata), 64'd0);
        @(negedge clk);
        // req suppresses a same-cycle start, including mthi
        run_op(4'd1, 32'd5, 32'd5, 0, 1'b1, 1'b1, 0, 32'h12345678, 32'h9ABCDEF0);
        run_op(4'd7, 32'h55555555, 32'd0, 0, 1'b1, 1'b0, 0, 32'h12345678, 32'h9ABCDEF0);
        // req during RUN does not cancel a committed div
        run_op(4'd3, 32'd100, 32'd7, 10, 1'b0, 1'b1, 3, 32'd2, 32'd14);
        // d_is_md low: no stall at any point
        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0, 0, 32'd0, 32'd1);

        // async reset in the middle of a mult
        run_op(4'd8, 32'h0BADF00D, 32'd0, 0, 1'b0, 1'b0, 0, 32'd0, 32'h0BADF00D);
        mdu_op = 4'd1; A = 32'd7; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; mdu_op = 4'd0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_hi", 64'(HI), 64'd0);
        chk("async_lo", 64'(LO), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_lo", 64'(LO), 64'd0);
        run_op(4'd1, 32'd6, 32'd7, 5, 1'b0, 1'b1, 0, 32'd0, 32'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit.
- Consumes the operands and control that the ID/EX pipeline register delivers to the E stage (forwarded RD1/RD2 and a decoded MDU op).
- Holds the architectural HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Supplies mfhi/mflo read data and the stall request used by the hazard unit, and honours the exception/interrupt `req` so that a flushed instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  exception/interrupt taken this cycle; suppresses any start.
- start  in  1  E-stage instruction is an MDU op that begins this cycle (op codes 1-4, 7, 8).
- mdu_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- d_is_md  in  1  instruction in D is any MDU op (codes 1-8).
- busy  out  1  multi-cycle operation in progress.
- stall  out  1  d_is_md & (busy | (start & ~req)); combinational.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- md_rdata  out  32  HI when mdu_op==5, LO when mdu_op==6, else 0; combinational.

Behaviour:
- Reset (async, immediate): HI=0, LO=0, busy=0, counter=0, state IDLE, pending result registers=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Effective start: eff = start & ~req & (state==IDLE). `start` while RUN is ignored; the hazard unit guarantees it never occurs, and the bench asserts it.
- In IDLE, on an edge with eff:
  - op 1 mult: pend{HI,LO} = signed(A)*signed(B), full 64-bit. counter=MULT_CYCLES. Go to RUN.
  - op 2 multu: pend{HI,LO} = unsigned product. counter=MULT_CYCLES. Go to RUN.
  - op 3 div:
    - pendLO = signed quotient, truncated toward zero; pendHI = remainder, sign of dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
    - counter=DIV_CYCLES. Go to RUN.
  - op 4 divu: unsigned quotient/remainder. counter=DIV_CYCLES. Go to RUN.
  - B==0 for op 3/4: enter RUN for DIV_CYCLES, but HI/LO stay unchanged at completion; a flag is latched.
  - op 7 mthi: HI<=A at this edge. Stay IDLE, busy stays 0.
  - op 8 mtlo: LO<=A at this edge. Stay IDLE, busy stays 0.
  - ops 0/5/6: no state change.
- Operands are latched at start. Later changes on A/B have no effect.
- RUN: counter decrements each edge. At the edge where counter goes 1→0:
  - HI/LO <= pend (unless the div-by-zero flag is set).
  - Return to IDLE; busy falls at that same edge.
- Timing: start sampled at edge t → busy=1 after edges t .. t+N-1 (exactly N cycles high); HI/LO new values visible after edge t+N; a new start is accepted at edge t+N.
- HI/LO are never visible as intermediate values while busy.
- req:
  - Blocks only a start in the same cycle (HI/LO and state untouched; mthi/mtlo also blocked).
  - An op already in RUN was committed earlier and runs to completion regardless of req.
- mfhi/mflo read HI/LO directly; during RUN they return the pre-op values. The stall prevents this from occurring architecturally.
- Reset asserted mid-RUN: immediate return to IDLE with HI=LO=0; the pending result is discarded.

Test Plan:
1. Reset, then A=0xFFFFFFFE, B=3, op=1, start 1 cycle → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with op=2 → HI=0x00000002, LO=0xFFFFFFFA.
2. A=0xFFFFFFF9 (-7), B=2, op=3 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 → LO=3, HI=1. div with B=0 → busy 10 cycles, HI/LO unchanged.
3. mthi with A=0x12345678, then mtlo with A=0x9ABCDEF0 → HI/LO updated the next edge, busy never asserts. mfhi/mflo → md_rdata=0x12345678 / 0x9ABCDEF0.
4. start+op=1 with req=1 in the same cycle → busy stays 0, HI/LO unchanged. Start a div, assert req at cycle 3 of RUN → div still completes at cycle 10 with correct values.
5. d_is_md=1 during start cycle and during all busy cycles → stall=1 each of those cycles; stall=0 on the cycle after busy falls; stall=0 whenever d_is_md=0.
6. Async reset pulse at cycle 4 of a mult (no clock edge) → busy, HI and LO go to 0 immediately; after release, the next start behaves normally.
